// File: rtl/sobel_obi_arbiter.sv
// Round-robin arbiter sharing one OBI manager port between NUM_REQ Sobel-side requesters.
// Address phases lock until granted; an in-order ID FIFO routes responses back.
module sobel_obi_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AW              = 32,
  parameter int DW              = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  input  logic [NUM_REQ*AW-1:0]              addr_i,
  input  logic [NUM_REQ-1:0]                 we_i,
  input  logic [NUM_REQ*4-1:0]               be_i,
  input  logic [NUM_REQ*DW-1:0]              wdata_i,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [DW-1:0]                      rdata_o,
  output logic                               err_o,
  output logic                               obi_req,
  input  logic                               obi_gnt,
  output logic [AW-1:0]                      obi_addr,
  output logic                               obi_we,
  output logic [3:0]                         obi_be,
  output logic [DW-1:0]                      obi_wdata,
  output logic [3:0]                         obi_aid,
  input  logic                               obi_rvalid,
  input  logic [DW-1:0]                      obi_rdata,
  input  logic                               obi_err,
  input  logic [3:0]                         obi_rid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               id_err_o
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   lock_idx;
  logic [IW-1:0]   rr_win;
  logic [IW-1:0]   winner;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [IW-1:0]   fifo_mem [MAX_OUTSTANDING];
  logic [IW-1:0]   head;
  logic            full, empty;
  logic            push, pop;
  logic            lock_drop;
  logic            id_err_q, id_err_set;

  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  // Round-robin pick: lowest distance from rr_ptr among active requesters.
  always_comb begin
    int best;
    int rank;
    rr_win = rr_ptr;
    best   = NUM_REQ;
    rank   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rank = k - int'(rr_ptr);
      if (rank < 0) rank = rank + NUM_REQ;
      if (req_i[k] && (rank < best)) begin
        best   = rank;
        rr_win = IW'(k);
      end
    end
  end

  assign winner    = (state_q == LOCK) ? lock_idx : rr_win;
  assign lock_drop = (state_q == LOCK) && !req_i[lock_idx];

  always_comb begin
    if (state_q == LOCK) obi_req = req_i[lock_idx] && !full;
    else                 obi_req = (|req_i) && !full;
  end

  assign push = obi_req && obi_gnt;
  assign pop  = obi_rvalid && !empty;
  assign head = fifo_mem[rd_ptr];

  // Address phase is zeroed whenever nothing is being requested downstream.
  always_comb begin
    obi_addr  = '0;
    obi_we    = 1'b0;
    obi_be    = '0;
    obi_wdata = '0;
    obi_aid   = '0;
    gnt_o     = '0;
    if (obi_req) begin
      obi_addr  = addr_i[int'(winner)*AW +: AW];
      obi_we    = we_i[winner];
      obi_be    = be_i[int'(winner)*4 +: 4];
      obi_wdata = wdata_i[int'(winner)*DW +: DW];
      obi_aid   = {{(4-IW){1'b0}}, winner};
    end
    if (push) gnt_o[winner] = 1'b1;
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (pop) begin
      rvalid_o[head] = 1'b1;
      rdata_o        = obi_rdata;
      err_o          = obi_err;
    end
  end

  assign id_err_set = lock_drop
                   || (obi_rvalid && empty)
                   || (pop && (obi_rid != {{(4-IW){1'b0}}, head}));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (obi_req && !obi_gnt) state_d = LOCK;
      LOCK:    if (push || lock_drop)   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      lock_idx <= '0;
      rr_ptr   <= '0;
      count_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      id_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ARB) && obi_req && !obi_gnt) lock_idx <= winner;
      if (push) begin
        rr_ptr <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (id_err_set) id_err_q <= 1'b1;
    end
  end

  // ID storage carries no reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= winner;
  end

  assign outstanding = count_q;
  assign id_err_o    = id_err_q;

endmodule

// File: tb/tb_sobel_obi_arbiter.sv
// Directed bench for sobel_obi_arbiter: vector table for arbitration/routing, hand sequences
// for back-pressure, protocol errors and mid-transaction reset.
module tb_sobel_obi_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_i;
  logic [1:0]   gnt_o;
  logic [63:0]  addr_i;
  logic [1:0]   we_i;
  logic [7:0]   be_i;
  logic [63:0]  wdata_i;
  logic [1:0]   rvalid_o;
  logic [31:0]  rdata_o;
  logic         err_o;
  logic         obi_req;
  logic         obi_gnt;
  logic [31:0]  obi_addr;
  logic         obi_we;
  logic [3:0]   obi_be;
  logic [31:0]  obi_wdata;
  logic [3:0]   obi_aid;
  logic         obi_rvalid;
  logic [31:0]  obi_rdata;
  logic         obi_err;
  logic [3:0]   obi_rid;
  logic [2:0]   outstanding;
  logic         id_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sobel_obi_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr),
    .obi_we(obi_we), .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_aid(obi_aid),
    .obi_rvalid(obi_rvalid), .obi_rdata(obi_rdata), .obi_err(obi_err), .obi_rid(obi_rid),
    .outstanding(outstanding), .id_err_o(id_err_o)
  );

  typedef struct {
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic [3:0] rid;
    logic [1:0] e_gnt;
    logic       e_req;
    logic [3:0] e_aid;
    logic [1:0] e_rvo;
    logic [2:0] e_out;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic g, input logic v,
                       input logic [3:0] id, input int tag);
    req_i      = r;
    obi_gnt    = g;
    obi_rvalid = v;
    obi_rid    = id;
    obi_rdata  = 32'h5A00_0000 | tag;
    obi_err    = (tag % 3 == 1);
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string name);
    drive(2'b00, 1'b0, 1'b0, 4'd0, 0);
    rst_n = 1'b0;
    #1;
    chk({name, "_outstanding"}, outstanding, 0);
    chk({name, "_gnt_o"}, gnt_o, 0);
    chk({name, "_obi_req"}, obi_req, 0);
    chk({name, "_rvalid_o"}, rvalid_o, 0);
    chk({name, "_id_err"}, id_err_o, 0);
    chk({name, "_addr"}, obi_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_rdata;
    logic        exp_err;
    // {req, gnt, rvalid, rid} -> {gnt_o, obi_req, obi_aid, rvalid_o, outstanding}
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00, 3'd0};
    tbl[1]  = '{2'b11, 1'b1, 1'b1, 4'd0, 2'b10, 1'b1, 4'd1, 2'b01, 3'd1};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 4'd1, 2'b01, 1'b1, 4'd0, 2'b10, 3'd1};
    tbl[3]  = '{2'b11, 1'b1, 1'b1, 4'd0, 2'b10, 1'b1, 4'd1, 2'b01, 3'd1};
    tbl[4]  = '{2'b00, 1'b1, 1'b1, 4'd1, 2'b00, 1'b0, 4'd0, 2'b10, 3'd1};
    tbl[5]  = '{2'b00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00, 3'd0};
    tbl[6]  = '{2'b01, 1'b1, 1'b0, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00, 3'd0};
    tbl[7]  = '{2'b01, 1'b1, 1'b0, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00, 3'd1};
    tbl[8]  = '{2'b10, 1'b1, 1'b1, 4'd0, 2'b10, 1'b1, 4'd1, 2'b01, 3'd2};
    tbl[9]  = '{2'b00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00, 3'd2};
    tbl[10] = '{2'b00, 1'b0, 1'b1, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01, 3'd2};
    tbl[11] = '{2'b00, 1'b0, 1'b1, 4'd1, 2'b00, 1'b0, 4'd0, 2'b10, 3'd1};
    tbl[12] = '{2'b00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00, 3'd0};
    tbl[13] = '{2'b01, 1'b1, 1'b0, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00, 3'd0};
    tbl[14] = '{2'b00, 1'b0, 1'b1, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01, 3'd1};
    tbl[15] = '{2'b01, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 4'd0, 2'b00, 3'd0};
    tbl[16] = '{2'b11, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 4'd0, 2'b00, 3'd0};
    tbl[17] = '{2'b11, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 4'd0, 2'b00, 3'd0};
    tbl[18] = '{2'b11, 1'b1, 1'b0, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00, 3'd0};
    tbl[19] = '{2'b11, 1'b1, 1'b1, 4'd0, 2'b10, 1'b1, 4'd1, 2'b01, 3'd1};
    tbl[20] = '{2'b00, 1'b0, 1'b1, 4'd1, 2'b00, 1'b0, 4'd0, 2'b10, 3'd1};
    tbl[21] = '{2'b00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00, 3'd0};

    addr_i     = {32'hA000_0001, 32'hA000_0000};
    wdata_i    = {32'hD000_0001, 32'hD000_0000};
    be_i       = {4'hC, 4'h3};
    we_i       = 2'b10;
    rst_n      = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 4'd0, 0);
    #1;
    chk("reset_outstanding", outstanding, 0);
    chk("reset_gnt_o", gnt_o, 0);
    chk("reset_obi_req", obi_req, 0);
    chk("reset_rvalid_o", rvalid_o, 0);
    chk("reset_id_err", id_err_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Alternating grants, routed responses, push/pop at outstanding=2, address lock.
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rid, i);
      exp_rdata = (tbl[i].e_rvo != 2'b00) ? (32'h5A00_0000 | i) : 32'h0;
      exp_err   = (tbl[i].e_rvo != 2'b00) && (i % 3 == 1);
      chk($sformatf("row%0d_gnt_o", i), gnt_o, tbl[i].e_gnt);
      chk($sformatf("row%0d_obi_req", i), obi_req, tbl[i].e_req);
      chk($sformatf("row%0d_obi_aid", i), obi_aid, tbl[i].e_aid);
      chk($sformatf("row%0d_obi_addr", i), obi_addr,
          tbl[i].e_req ? (32'hA000_0000 | tbl[i].e_aid) : 32'h0);
      chk($sformatf("row%0d_obi_be", i), obi_be,
          tbl[i].e_req ? (tbl[i].e_aid[0] ? 4'hC : 4'h3) : 4'h0);
      chk($sformatf("row%0d_rvalid_o", i), rvalid_o, tbl[i].e_rvo);
      chk($sformatf("row%0d_rdata_o", i), rdata_o, exp_rdata);
      chk($sformatf("row%0d_err_o", i), err_o, exp_err);
      chk($sformatf("row%0d_outstanding", i), outstanding, tbl[i].e_out);
      chk($sformatf("row%0d_id_err", i), id_err_o, 1'b0);
      tick();
    end

    // Fill to MAX_OUTSTANDING, then one response frees a slot for the fifth request.
    for (int n = 0; n < 4; n++) begin
      drive(2'b01, 1'b1, 1'b0, 4'd0, 100);
      chk($sformatf("fill%0d_gnt_o", n), gnt_o, 2'b01);
      chk($sformatf("fill%0d_outstanding", n), outstanding, n);
      tick();
    end
    drive(2'b01, 1'b1, 1'b0, 4'd0, 100);
    chk("full_obi_req", obi_req, 0);
    chk("full_gnt_o", gnt_o, 0);
    chk("full_outstanding", outstanding, 4);
    tick();
    drive(2'b01, 1'b1, 1'b1, 4'd0, 100);
    chk("full_pop_obi_req", obi_req, 0);
    chk("full_pop_rvalid_o", rvalid_o, 2'b01);
    tick();
    drive(2'b01, 1'b1, 1'b0, 4'd0, 100);
    chk("fifth_outstanding", outstanding, 3);
    chk("fifth_gnt_o", gnt_o, 2'b01);
    tick();
    for (int n = 0; n < 4; n++) begin
      drive(2'b00, 1'b0, 1'b1, 4'd0, 100);
      chk($sformatf("drain%0d_rvalid_o", n), rvalid_o, 2'b01);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 4'd0, 100);
    chk("drained_outstanding", outstanding, 0);
    chk("drained_id_err", id_err_o, 0);

    // Response ID mismatch: routing follows the FIFO head, flag goes sticky.
    drive(2'b01, 1'b1, 1'b0, 4'd0, 200);
    tick();
    drive(2'b00, 1'b0, 1'b1, 4'd1, 200);
    chk("rid_mismatch_rvalid_o", rvalid_o, 2'b01);
    tick();
    drive(2'b00, 1'b0, 1'b0, 4'd0, 200);
    chk("rid_mismatch_id_err", id_err_o, 1);
    tick();
    chk("rid_mismatch_sticky", id_err_o, 1);
    pulse_reset("rst_a");

    // Response with nothing outstanding.
    drive(2'b00, 1'b0, 1'b1, 4'd0, 300);
    chk("empty_rv_rvalid_o", rvalid_o, 2'b00);
    tick();
    drive(2'b00, 1'b0, 1'b0, 4'd0, 300);
    chk("empty_rv_id_err", id_err_o, 1);
    pulse_reset("rst_b");

    // Locked requester withdraws before grant.
    drive(2'b01, 1'b0, 1'b0, 4'd0, 400);
    chk("lock_obi_req", obi_req, 1);
    tick();
    drive(2'b00, 1'b0, 1'b0, 4'd0, 400);
    chk("lock_drop_obi_req", obi_req, 0);
    tick();
    chk("lock_drop_id_err", id_err_o, 1);
    pulse_reset("rst_c");

    // Reset with three in flight and rr_ptr advanced; a late response is then orphaned.
    for (int n = 0; n < 3; n++) begin
      drive(2'b01, 1'b1, 1'b0, 4'd0, 500);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 4'd0, 500);
    chk("pre_rst_outstanding", outstanding, 3);
    pulse_reset("rst_mid");
    drive(2'b00, 1'b0, 1'b1, 4'd0, 500);
    chk("late_rv_rvalid_o", rvalid_o, 2'b00);
    tick();
    drive(2'b11, 1'b1, 1'b0, 4'd0, 500);
    chk("late_rv_id_err", id_err_o, 1);
    chk("post_rst_rr_gnt_o", gnt_o, 2'b01);
    chk("post_rst_rr_aid", obi_aid, 0);
    tick();
    drive(2'b00, 1'b0, 1'b0, 4'd0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
